pipe_hazard_ctrl: RTL and testbench

Central pipeline sequencer for the 4-bit-register, five-stage CPU. It decides per cycle which pipeline registers advance, hold or take a bubble. It covers load-use stalls (multi-cycle load latency), data-memory wait freezes with timeout, taken-branch flushes and the halt drain. Operand forwarding stays in the separate forwarding unit; this block handles only the hazards forwarding cannot resolve.

---
 rtl/pipe_hazard_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: per-cycle advance/hold/bubble sequencer for the five-stage CPU.
// Rev 1.0 - load-use stalls, memory freeze with timeout, branch flush, halt drain.
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int LOAD_LAT    = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       IF_ID_r1,
    input  logic [3:0]       IF_ID_r2,
    input  logic             IF_ID_use1,
    input  logic             IF_ID_use2,
    input  logic             IF_ID_hlt,
    input  logic [3:0]       ID_EX_wr,
    input  logic             ID_EX_memrd,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_write,
    output logic             ID_EX_flush,
    output logic             EX_MEM_write,
    output logic             MEM_WB_flush,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LUSE   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [2:0] LAT_INIT = 3'(LOAD_LAT - 1);
    localparam logic [7:0] TIMEOUT  = 8'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [2:0]       lat_cnt_q, lat_cnt_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [1:0]       drain_cnt_q, drain_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_f, halt_o;
    logic hazard;

    // Register 0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign hazard = ID_EX_memrd && (ID_EX_wr != 4'd0) &&
                    ((IF_ID_use1 && (IF_ID_r1 == ID_EX_wr)) ||
                     (IF_ID_use2 && (IF_ID_r2 == ID_EX_wr)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            lat_cnt_q   <= 3'd0;
            wait_cnt_q  <= 8'd0;
            drain_cnt_q <= 2'd0;
            mem_err_q   <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_q     <= stall_d;
        end
    end

    always_comb begin
        pc_w        = 1'b1;
        ifid_w      = 1'b1;
        ifid_f      = 1'b0;
        idex_w      = 1'b1;
        idex_f      = 1'b0;
        exmem_w     = 1'b1;
        memwb_f     = 1'b0;
        halt_o      = 1'b0;
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        wait_cnt_d  = 8'd0;
        mem_err_d   = mem_err_q;

        if (state_q == ST_HALTED) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            idex_w  = 1'b0;
            exmem_w = 1'b0;
            halt_o  = 1'b1;
        end else if (mem_busy) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            idex_w  = 1'b0;
            exmem_w = 1'b0;
            memwb_f = 1'b1;
            wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
            if (wait_cnt_d >= TIMEOUT) begin
                mem_err_d = 1'b1;
            end
        end else if (branch_taken && (state_q != ST_DRAIN)) begin
            ifid_f    = 1'b1;
            idex_f    = 1'b1;
            state_d   = ST_RUN;
            lat_cnt_d = 3'd0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (hazard) begin
                        pc_w   = 1'b0;
                        ifid_w = 1'b0;
                        idex_f = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d   = ST_LUSE;
                            lat_cnt_d = LAT_INIT;
                        end
                    end else if (IF_ID_hlt) begin
                        pc_w        = 1'b0;
                        ifid_f      = 1'b1;
                        state_d     = ST_DRAIN;
                        drain_cnt_d = 2'd3;
                    end
                end
                ST_LUSE: begin
                    pc_w   = 1'b0;
                    ifid_w = 1'b0;
                    idex_f = 1'b1;
                    if (lat_cnt_q <= 3'd1) begin
                        state_d   = ST_RUN;
                        lat_cnt_d = 3'd0;
                    end else begin
                        lat_cnt_d = lat_cnt_q - 3'd1;
                    end
                end
                ST_DRAIN: begin
                    pc_w   = 1'b0;
                    ifid_f = 1'b1;
                    idex_f = 1'b1;
                    if (drain_cnt_q <= 2'd1) begin
                        state_d     = ST_HALTED;
                        drain_cnt_d = 2'd0;
                    end else begin
                        drain_cnt_d = drain_cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        stall_d = stall_q;
        if (!pc_w && (state_q != ST_HALTED) && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // Reset forces every stage to hold/bubble without waiting for a clock.
    assign pc_write     = rst_n & pc_w;
    assign IF_ID_write  = rst_n & ifid_w;
    assign IF_ID_flush  = ~rst_n | ifid_f;
    assign ID_EX_write  = rst_n & idex_w;
    assign ID_EX_flush  = ~rst_n | idex_f;
    assign EX_MEM_write = rst_n & exmem_w;
    assign MEM_WB_flush = ~rst_n | memwb_f;
    assign halted       = rst_n & halt_o;
    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed bench with two DUT configurations checked against a behavioural model.
`default_nettype none

module tb_pipe_hazard_ctrl;
    localparam int CW = 16;

    // Output vector order: pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_write, MEM_WB_flush, halted
    localparam logic [7:0] V_RST = 8'b0010_1010;
    localparam logic [7:0] V_DEF = 8'b1101_0100;
    localparam logic [7:0] V_HLD = 8'b0000_0001;
    localparam logic [7:0] V_FRZ = 8'b0000_0010;
    localparam logic [7:0] V_BR  = 8'b1111_1100;
    localparam logic [7:0] V_LU  = 8'b0001_1100;
    localparam logic [7:0] V_HLT = 8'b0111_0100;
    localparam logic [7:0] V_DRN = 8'b0111_1100;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [3:0] IF_ID_r1, IF_ID_r2, ID_EX_wr;
    logic IF_ID_use1, IF_ID_use2, IF_ID_hlt, ID_EX_memrd, branch_taken, mem_busy;

    logic [7:0]    out_a, out_b;
    logic          err_a, err_b;
    logic [CW-1:0] stall_a, stall_b;

    int total = 0;
    int bad = 0;

    int LAT [2] = '{1, 3};
    int TMO [2] = '{255, 3};
    int pend [2];
    int drn [2];
    int wcnt [2];
    int stalls [2];
    bit hlt_st [2];
    bit err [2];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.LOAD_LAT(1), .MEM_TIMEOUT(255), .CNT_W(CW)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_r1(IF_ID_r1), .IF_ID_r2(IF_ID_r2), .IF_ID_use1(IF_ID_use1), .IF_ID_use2(IF_ID_use2),
        .IF_ID_hlt(IF_ID_hlt), .ID_EX_wr(ID_EX_wr), .ID_EX_memrd(ID_EX_memrd),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(out_a[7]), .IF_ID_write(out_a[6]), .IF_ID_flush(out_a[5]), .ID_EX_write(out_a[4]),
        .ID_EX_flush(out_a[3]), .EX_MEM_write(out_a[2]), .MEM_WB_flush(out_a[1]), .halted(out_a[0]),
        .mem_err(err_a), .stall_cycles(stall_a)
    );

    pipe_hazard_ctrl #(.LOAD_LAT(3), .MEM_TIMEOUT(3), .CNT_W(CW)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_r1(IF_ID_r1), .IF_ID_r2(IF_ID_r2), .IF_ID_use1(IF_ID_use1), .IF_ID_use2(IF_ID_use2),
        .IF_ID_hlt(IF_ID_hlt), .ID_EX_wr(ID_EX_wr), .ID_EX_memrd(ID_EX_memrd),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(out_b[7]), .IF_ID_write(out_b[6]), .IF_ID_flush(out_b[5]), .ID_EX_write(out_b[4]),
        .ID_EX_flush(out_b[3]), .EX_MEM_write(out_b[2]), .MEM_WB_flush(out_b[1]), .halted(out_b[0]),
        .mem_err(err_b), .stall_cycles(stall_b)
    );

    function automatic bit hz();
        return ID_EX_memrd && (ID_EX_wr != 4'd0) &&
               ((IF_ID_use1 && (IF_ID_r1 == ID_EX_wr)) || (IF_ID_use2 && (IF_ID_r2 == ID_EX_wr)));
    endfunction

    // pend = load-use bubbles still owed after this one; drn = drain cycles left before halting
    function automatic logic [7:0] exp_vec(int k);
        if (!rst_n)                            return V_RST;
        if (hlt_st[k])                         return V_HLD;
        if (mem_busy)                          return V_FRZ;
        if (branch_taken && drn[k] == 0)       return V_BR;
        if (pend[k] > 0 || (drn[k] == 0 && hz())) return V_LU;
        if (drn[k] > 0)                        return V_DRN;
        if (IF_ID_hlt)                         return V_HLT;
        return V_DEF;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                pend[k] = 0; drn[k] = 0; wcnt[k] = 0; stalls[k] = 0; hlt_st[k] = 0; err[k] = 0;
            end else begin
                logic [7:0] v;
                v = exp_vec(k);
                if (!v[7] && !v[0] && stalls[k] < 65535) stalls[k]++;
                if (hlt_st[k]) begin
                    wcnt[k] = 0;
                end else if (mem_busy) begin
                    if (wcnt[k] < 255) wcnt[k]++;
                    if (wcnt[k] >= TMO[k]) err[k] = 1;
                end else begin
                    wcnt[k] = 0;
                    if (branch_taken && drn[k] == 0) pend[k] = 0;
                    else if (pend[k] > 0) pend[k]--;
                    else if (drn[k] > 0) begin
                        drn[k]--;
                        if (drn[k] == 0) hlt_st[k] = 1;
                    end
                    else if (hz()) pend[k] = LAT[k] - 1;
                    else if (IF_ID_hlt) drn[k] = 3;
                end
            end
        end
    end

    task automatic cmp_dut(input int k, input string nm, input logic [7:0] v,
                           input logic [CW-1:0] sc, input logic me);
        logic [7:0] e;
        e = exp_vec(k);
        total += 3;
        if (v !== e) begin
            bad++;
            $display("FAIL %s ctrl at %0t: got %b want %b", nm, $time, v, e);
        end
        if (sc !== CW'(stalls[k])) begin
            bad++;
            $display("FAIL %s stall_cycles at %0t: got %0d want %0d", nm, $time, sc, stalls[k]);
        end
        if (me !== err[k]) begin
            bad++;
            $display("FAIL %s mem_err at %0t: got %b want %b", nm, $time, me, err[k]);
        end
    endtask

    always @(negedge clk) begin
        cmp_dut(0, "dutA", out_a, stall_a, err_a);
        cmp_dut(1, "dutB", out_b, stall_b, err_b);
    end

    task automatic lit(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        IF_ID_r1 = 4'd0; IF_ID_r2 = 4'd0; IF_ID_use1 = 1'b0; IF_ID_use2 = 1'b0;
        IF_ID_hlt = 1'b0; ID_EX_wr = 4'd0; ID_EX_memrd = 1'b0;
        branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic load_use_r1();
        ID_EX_memrd = 1'b1; ID_EX_wr = 4'd5; IF_ID_r1 = 4'd5; IF_ID_use1 = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        #1 rst_n = 1'b0;
        tick(2);
        lit("reset pc_write", int'(out_a[7]), 0);
        lit("reset IF_ID_flush", int'(out_b[5]), 1);
        lit("reset stall_cycles", int'(stall_b), 0);
        rst_n = 1'b1;
        tick(1);

        // load-use on r1
        load_use_r1();
        tick(1);
        idle();
        tick(4);
        lit("loaduse lat1 stalls", int'(stall_a), 1);
        lit("loaduse lat3 stalls", int'(stall_b), 3);

        // r0 destination and unused operand never stall; then a real r2 hazard
        do_reset();
        ID_EX_memrd = 1'b1; ID_EX_wr = 4'd0; IF_ID_r1 = 4'd0; IF_ID_use1 = 1'b1;
        tick(1);
        ID_EX_wr = 4'd7; IF_ID_r1 = 4'd3; IF_ID_r2 = 4'd7; IF_ID_use2 = 1'b0;
        tick(1);
        lit("no hazard stalls", int'(stall_b), 0);
        IF_ID_use2 = 1'b1;
        tick(1);
        idle();
        tick(4);
        lit("r2 hazard lat3 stalls", int'(stall_b), 3);

        // branch beats hazard; branch in second LUSE cycle
        do_reset();
        load_use_r1();
        branch_taken = 1'b1;
        tick(1);
        idle();
        lit("branch+hazard stalls", int'(stall_a), 0);
        tick(1);
        load_use_r1();
        tick(1);
        idle();
        branch_taken = 1'b1;
        tick(1);
        idle();
        tick(2);
        lit("branch in LUSE stalls", int'(stall_b), 1);

        // freeze during LUSE
        do_reset();
        load_use_r1();
        tick(1);
        idle();
        mem_busy = 1'b1;
        tick(4);
        mem_busy = 1'b0;
        tick(4);
        lit("freeze lat3 stalls", int'(stall_b), 7);
        lit("freeze lat1 stalls", int'(stall_a), 5);
        lit("freeze timeout err", int'(err_b), 1);

        // timeout threshold
        do_reset();
        mem_busy = 1'b1;
        tick(2);
        mem_busy = 1'b0;
        tick(1);
        lit("busy2 no err", int'(err_b), 0);
        mem_busy = 1'b1;
        tick(3);
        mem_busy = 1'b0;
        tick(2);
        lit("busy3 err sticky", int'(err_b), 1);
        lit("long timeout no err", int'(err_a), 0);

        // halt and drain
        do_reset();
        IF_ID_hlt = 1'b1;
        tick(1);
        idle();
        tick(3);
        lit("halted", int'(out_a[0]), 1);
        lit("halt stalls", int'(stall_b), 4);
        mem_busy = 1'b1;
        branch_taken = 1'b1;
        tick(3);
        idle();
        lit("halted stalls hold", int'(stall_a), 4);
        lit("halted ignores busy", int'(out_b[1]), 0);

        // asynchronous reset mid-drain
        do_reset();
        IF_ID_hlt = 1'b1;
        tick(1);
        idle();
        tick(1);
        #1 rst_n = 1'b0;
        #1;
        lit("async rst pc_write", int'(out_b[7]), 0);
        lit("async rst ID_EX_flush", int'(out_b[3]), 1);
        lit("async rst stall", int'(stall_b), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick(1);
        lit("post rst pc_write", int'(out_b[7]), 1);
        lit("post rst stall", int'(stall_a), 0);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
